// File: rtl/led_strand_driver.sv
// rtl/led_strand_driver.sv - WS2812-style serial LED strand transmitter with per-LED color requests
// Optional feature macro: LED_STRAND_TIMEOUT_EN (color-wait watchdog and sticky timeout_error)
module led_strand_driver #(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 6,
  parameter int REQ_LATENCY       = 2,
  parameter int T0H_CYCLES        = 35,
  parameter int T0L_CYCLES        = 80,
  parameter int T1H_CYCLES        = 70,
  parameter int T1L_CYCLES        = 60,
  parameter int RESET_CYCLES      = 5000,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  output logic [LED_ADDRESS_WIDTH:0] next_led_request,
  input  logic [7:0]                 green_in,
  input  logic [7:0]                 red_in,
  input  logic [7:0]                 blue_in,
  input  logic                       color_valid,
  output logic                       strand_out,
  output logic                       busy,
  output logic                       frame_done
`ifdef LED_STRAND_TIMEOUT_EN
  ,
  output logic                       timeout_error
`endif
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One timer serves settle, bit-high, bit-low and latch periods, so it is sized for the longest.
  localparam int MAX_T = max2(max2(max2(T0H_CYCLES, T0L_CYCLES), max2(T1H_CYCLES, T1L_CYCLES)),
                              max2(max2(RESET_CYCLES, REQ_LATENCY), TIMEOUT_CYCLES));
  localparam int CW = $clog2(MAX_T) + 1;
  localparam int AW = LED_ADDRESS_WIDTH + 1;

  localparam logic [AW-1:0] LAST_LED  = AW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] SETTLE    = CW'(REQ_LATENCY);
  localparam logic [CW-1:0] T0H_M1    = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] T0L_M1    = CW'(T0L_CYCLES - 1);
  localparam logic [CW-1:0] T1H_M1    = CW'(T1H_CYCLES - 1);
  localparam logic [CW-1:0] T1L_M1    = CW'(T1L_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_M1  = CW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_COLOR, BIT_HIGH, BIT_LOW, LATCH} state_t;

  state_t        state;
  logic [CW-1:0] timer;
  logic [23:0]   shift_reg;
  logic [4:0]    bit_count;
`ifdef LED_STRAND_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] watchdog;
`endif

  // Frame sequencer: request colors, serialise each GRB word MSB first, then hold the latch low time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      timer            <= '0;
      shift_reg        <= '0;
      bit_count        <= '0;
      next_led_request <= '0;
      strand_out       <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
`ifdef LED_STRAND_TIMEOUT_EN
      watchdog         <= '0;
      timeout_error    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          strand_out <= 1'b0;
          if (enable) begin
            next_led_request <= '0;
            busy             <= 1'b1;
            timer            <= SETTLE;
`ifdef LED_STRAND_TIMEOUT_EN
            watchdog         <= '0;
`endif
            state            <= WAIT_COLOR;
          end
        end
        WAIT_COLOR: begin
          strand_out <= 1'b0;
          // Data arriving before the source's read latency has elapsed belongs to the previous index.
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (color_valid) begin
            shift_reg  <= {green_in, red_in, blue_in};
            bit_count  <= '0;
            strand_out <= 1'b1;
            timer      <= green_in[7] ? T1H_M1 : T0H_M1;
            state      <= BIT_HIGH;
          end
`ifdef LED_STRAND_TIMEOUT_EN
          else if (watchdog == TIMEOUT_M1) begin
            // Silent source: send black so the strand stays in step, and flag it.
            shift_reg     <= '0;
            bit_count     <= '0;
            strand_out    <= 1'b1;
            timer         <= T0H_M1;
            timeout_error <= 1'b1;
            state         <= BIT_HIGH;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
`endif
        end
        BIT_HIGH: begin
          if (timer == '0) begin
            strand_out <= 1'b0;
            timer      <= shift_reg[23] ? T1L_M1 : T0L_M1;
            state      <= BIT_LOW;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        BIT_LOW: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            shift_reg <= {shift_reg[22:0], 1'b0};
            bit_count <= bit_count + 1'b1;
            if (bit_count != 5'd23) begin
              strand_out <= 1'b1;
              timer      <= shift_reg[22] ? T1H_M1 : T0H_M1;
              state      <= BIT_HIGH;
            end else if (next_led_request == LAST_LED) begin
              timer <= LATCH_M1;
              state <= LATCH;
            end else begin
              next_led_request <= next_led_request + 1'b1;
              timer            <= SETTLE;
`ifdef LED_STRAND_TIMEOUT_EN
              watchdog         <= '0;
`endif
              state            <= WAIT_COLOR;
            end
          end
        end
        LATCH: begin
          strand_out <= 1'b0;
          if (timer == '0) begin
            frame_done       <= 1'b1;
            busy             <= 1'b0;
            next_led_request <= '0;
            state            <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          strand_out <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_strand_driver.sv
// tb/tb_led_strand_driver.sv - directed self-checking bench for led_strand_driver
module tb_led_strand_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // DUT A: single LED, full-size timing
  logic       en_a, cv_a;
  logic [7:0] g_a, r_a, b_a;
  logic [6:0] req_a;
  logic       so_a, busy_a, fd_a;

  // DUT B: four LEDs, shortened timing
  logic       en_b;
  logic       cv_b;
  logic [7:0] g_b, r_b, b_b;
  logic [6:0] req_b;
  logic       so_b, busy_b, fd_b;

`ifdef LED_STRAND_TIMEOUT_EN
  logic       te_a, te_b;
  logic       en_c;
  logic [7:0] g_c, r_c, b_c;
  logic       cv_c;
  logic [6:0] req_c;
  logic       so_c, busy_c, fd_c, te_c;
`endif

  led_strand_driver #(.NUM_LEDS(1)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .next_led_request(req_a),
    .green_in(g_a), .red_in(r_a), .blue_in(b_a), .color_valid(cv_a),
    .strand_out(so_a), .busy(busy_a), .frame_done(fd_a)
`ifdef LED_STRAND_TIMEOUT_EN
    , .timeout_error(te_a)
`endif
  );

  led_strand_driver #(.NUM_LEDS(4), .T0H_CYCLES(3), .T0L_CYCLES(5), .T1H_CYCLES(6),
                      .T1L_CYCLES(4), .RESET_CYCLES(20)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .next_led_request(req_b),
    .green_in(g_b), .red_in(r_b), .blue_in(b_b), .color_valid(cv_b),
    .strand_out(so_b), .busy(busy_b), .frame_done(fd_b)
`ifdef LED_STRAND_TIMEOUT_EN
    , .timeout_error(te_b)
`endif
  );

`ifdef LED_STRAND_TIMEOUT_EN
  led_strand_driver #(.NUM_LEDS(2), .T0H_CYCLES(3), .T0L_CYCLES(5), .T1H_CYCLES(6),
                      .T1L_CYCLES(4), .RESET_CYCLES(20), .TIMEOUT_CYCLES(10)) dut_c (
    .clk(clk), .rst(rst), .enable(en_c), .next_led_request(req_c),
    .green_in(g_c), .red_in(r_c), .blue_in(b_c), .color_valid(cv_c),
    .strand_out(so_c), .busy(busy_c), .frame_done(fd_c), .timeout_error(te_c)
  );
`endif

  // Color of LED i as served by the bench's source for DUT B
  function automatic logic [23:0] col_b(input int i);
    logic [7:0] g, r, b;
    g = 8'h11 * 8'(i + 1);
    r = 8'hC3 ^ 8'(i);
    b = 8'h0F + 8'(i) * 8'h20;
    return {g, r, b};
  endfunction

  // Source for DUT B: always valid, data follows the request after a two-cycle read latency
  logic [23:0] d1_b = '0, d2_b = '0;
  always @(posedge clk) begin
    d1_b <= col_b(int'(req_b));
    d2_b <= d1_b;
  end
  assign cv_b = 1'b1;
  assign {g_b, r_b, b_b} = d2_b;

  // Monitor A: high widths and timestamps
  int widths_a[$];
  int hi_a = 0, fall_cyc_a = 0, fd_cyc_a = 0;
  // Monitor B: decoded words, request changes, frame_done count
  logic [23:0] words_b[$];
  int          reqs_b[$];
  int          hi_b = 0, nbits_b = 0, fd_count_b = 0;
  logic [23:0] word_b = '0;
  logic [6:0]  prev_req_b = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      hi_a = 0; hi_b = 0; nbits_b = 0; word_b = '0; prev_req_b = '0;
    end else begin
      if (so_a) hi_a++;
      else if (hi_a != 0) begin widths_a.push_back(hi_a); hi_a = 0; fall_cyc_a = cyc; end
      if (fd_a) fd_cyc_a = cyc;
      if (so_b) hi_b++;
      else if (hi_b != 0) begin
        word_b = {word_b[22:0], (hi_b >= 5)};
        hi_b = 0;
        nbits_b++;
        if (nbits_b == 24) begin words_b.push_back(word_b); nbits_b = 0; end
      end
      if (req_b != prev_req_b) begin reqs_b.push_back(int'(req_b)); prev_req_b = req_b; end
      if (fd_b) fd_count_b++;
    end
  end

  task automatic test_reset();
    n_cmp++; if (so_a !== 1'b0)   begin n_bad++; $display("FAIL reset_so_a: got %b want 0", so_a); end
    n_cmp++; if (req_a !== 7'd0)  begin n_bad++; $display("FAIL reset_req_a: got %0d want 0", req_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    n_cmp++; if (fd_a !== 1'b0)   begin n_bad++; $display("FAIL reset_fd_a: got %b want 0", fd_a); end
    n_cmp++; if (so_b !== 1'b0)   begin n_bad++; $display("FAIL reset_so_b: got %b want 0", so_b); end
    n_cmp++; if (req_b !== 7'd0)  begin n_bad++; $display("FAIL reset_req_b: got %0d want 0", req_b); end
    n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
`ifdef LED_STRAND_TIMEOUT_EN
    n_cmp++; if (te_c !== 1'b0)   begin n_bad++; $display("FAIL reset_te_c: got %b want 0", te_c); end
`endif
  endtask

  task automatic test_single_led();
    logic [23:0] pat;
    int exp_w, k;
    bit ok;
    pat = 24'hA500FF;
    widths_a.delete();
    @(negedge clk) en_a = 1'b1;
    @(negedge clk) en_a = 1'b0;
    repeat (3) @(negedge clk);
    g_a = 8'hA5; r_a = 8'h00; b_a = 8'hFF; cv_a = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (so_a) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_first_rise: got no rise want rise within 20"); end
    cv_a = 1'b0; g_a = 8'h00; r_a = 8'hFF; b_a = 8'h00;
    ok = 1'b0;
    for (k = 0; k < 12000; k++) begin
      @(negedge clk);
      if (fd_a) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_frame_done: got timeout want pulse"); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL single_busy_with_done: got %b want 0", busy_a); end
    @(negedge clk);
    n_cmp++; if (widths_a.size() != 24) begin n_bad++; $display("FAIL single_bit_count: got %0d want 24", widths_a.size()); end
    for (int i = 0; i < 24; i++) begin
      exp_w = pat[23-i] ? 70 : 35;
      n_cmp++;
      if (i >= widths_a.size()) begin
        n_bad++; $display("FAIL single_width[%0d]: got none want %0d", i, exp_w);
      end else if (widths_a[i] != exp_w) begin
        n_bad++; $display("FAIL single_width[%0d]: got %0d want %0d", i, widths_a[i], exp_w);
      end
    end
    // last bit is a 1: 60 low cycles, then 5000 latch cycles, then the pulse
    n_cmp++;
    if (fd_cyc_a - fall_cyc_a != 5060) begin
      n_bad++; $display("FAIL single_latch_time: got %0d want 5060", fd_cyc_a - fall_cyc_a);
    end
  endtask

  task automatic test_request_sequence();
    int exp_req[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int k, gap;
    bit ok;
    reqs_b.delete(); words_b.delete(); fd_count_b = 0;
    @(negedge clk) en_b = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (fd_b) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL seq_first_done: got timeout want pulse"); end
    gap = 0;
    while (!busy_b && gap < 10) begin gap++; @(negedge clk); end
    n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL seq_idle_gap: got %0d want 1", gap); end
    ok = 1'b0;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (fd_b) begin ok = 1'b1; break; end
    end
    en_b = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL seq_second_done: got timeout want pulse"); end
    repeat (5) @(negedge clk);
    n_cmp++; if (fd_count_b != 2) begin n_bad++; $display("FAIL seq_done_count: got %0d want 2", fd_count_b); end
    n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL seq_busy_after: got %b want 0", busy_b); end
    n_cmp++; if (reqs_b.size() != 8) begin n_bad++; $display("FAIL seq_req_count: got %0d want 8", reqs_b.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= reqs_b.size()) begin n_bad++; $display("FAIL seq_req[%0d]: got none want %0d", i, exp_req[i]); end
      else if (reqs_b[i] != exp_req[i]) begin
        n_bad++; $display("FAIL seq_req[%0d]: got %0d want %0d", i, reqs_b[i], exp_req[i]);
      end
    end
    n_cmp++; if (words_b.size() != 8) begin n_bad++; $display("FAIL settle_word_count: got %0d want 8", words_b.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= words_b.size()) begin n_bad++; $display("FAIL settle_word[%0d]: got none want %06h", i, col_b(i % 4)); end
      else if (words_b[i] !== col_b(i % 4)) begin
        n_bad++; $display("FAIL settle_word[%0d]: got %06h want %06h", i, words_b[i], col_b(i % 4));
      end
    end
  endtask

  task automatic test_enable_drop();
    int k;
    bit ok;
    words_b.delete(); fd_count_b = 0;
    @(negedge clk) en_b = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (req_b == 7'd1) begin ok = 1'b1; break; end
    end
    en_b = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_reach_led1: got timeout want req 1"); end
    ok = 1'b0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (fd_b) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_frame_done: got timeout want pulse"); end
    repeat (30) @(negedge clk);
    n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", busy_b); end
    n_cmp++; if (fd_count_b != 1) begin n_bad++; $display("FAIL drop_done_count: got %0d want 1", fd_count_b); end
    n_cmp++; if (words_b.size() != 4) begin n_bad++; $display("FAIL drop_words: got %0d want 4", words_b.size()); end
    n_cmp++; if (req_b !== 7'd0) begin n_bad++; $display("FAIL drop_req: got %0d want 0", req_b); end
  endtask

  task automatic test_reset_mid_bit();
    int k;
    bit ok;
    @(negedge clk) en_b = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (req_b == 7'd2 && so_b) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_reach_led2_high: got timeout want high bit"); end
    rst = 1'b1; en_b = 1'b0;
    @(negedge clk);
    n_cmp++; if (so_b !== 1'b0)   begin n_bad++; $display("FAIL rst_mid_so: got %b want 0", so_b); end
    n_cmp++; if (req_b !== 7'd0)  begin n_bad++; $display("FAIL rst_mid_req: got %0d want 0", req_b); end
    n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy_b); end
    @(negedge clk);
    rst = 1'b0;
    words_b.delete();
    en_b = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (fd_b) begin ok = 1'b1; break; end
    end
    en_b = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_restart_done: got timeout want pulse"); end
    n_cmp++; if (words_b.size() != 4) begin n_bad++; $display("FAIL rst_restart_words: got %0d want 4", words_b.size()); end
    n_cmp++;
    if (words_b.size() < 1) begin n_bad++; $display("FAIL rst_restart_led0: got none want %06h", col_b(0)); end
    else if (words_b[0] !== col_b(0)) begin
      n_bad++; $display("FAIL rst_restart_led0: got %06h want %06h", words_b[0], col_b(0));
    end
  endtask

`ifdef LED_STRAND_TIMEOUT_EN
  task automatic test_timeout();
    int k, hi, rises, bad_w;
    bit ok;
    hi = 0; rises = 0; bad_w = 0;
    @(negedge clk) en_c = 1'b1;
    @(negedge clk) en_c = 1'b0;
    ok = 1'b0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (req_c == 7'd1) begin ok = 1'b1; break; end
      if (so_c) hi++;
      else if (hi != 0) begin rises++; if (hi != 3) bad_w++; hi = 0; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_advance: got timeout want req 1"); end
    n_cmp++; if (rises != 24) begin n_bad++; $display("FAIL to_bits: got %0d want 24", rises); end
    n_cmp++; if (bad_w != 0) begin n_bad++; $display("FAIL to_zero_bits: got %0d non-zero bits want 0", bad_w); end
    n_cmp++; if (te_c !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b want 1", te_c); end
    repeat (400) @(negedge clk);
    n_cmp++; if (te_c !== 1'b1) begin n_bad++; $display("FAIL to_flag_held: got %b want 1", te_c); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    en_a = 1'b0; cv_a = 1'b0; g_a = '0; r_a = '0; b_a = '0;
    en_b = 1'b0;
`ifdef LED_STRAND_TIMEOUT_EN
    en_c = 1'b0; cv_c = 1'b0; g_c = 8'hFF; r_c = 8'hFF; b_c = 8'hFF;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_single_led();
    test_request_sequence();
    test_enable_drop();
    test_reset_mid_bit();
`ifdef LED_STRAND_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
